// File: rtl/main_fsm.sv
// Multicycle ARM control FSM: Moore decode of an internal state register into datapath selects and ungated write enables.
// Optional retired-instruction counter is built when MAIN_FSM_RETIRE_CNT_EN is defined.
module main_fsm #(
   parameter int STATE_W      = 4,
   parameter int UNKNOWN_HOLD = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               ALUOp,
   output logic [STATE_W-1:0] State
`ifdef MAIN_FSM_RETIRE_CNT_EN
   ,
   output logic [31:0]        RetireCnt
`endif
);

   typedef enum logic [STATE_W-1:0] {
      FETCH    = STATE_W'(0),
      DECODE   = STATE_W'(1),
      MEMADR   = STATE_W'(2),
      MEMRD    = STATE_W'(3),
      MEMWB    = STATE_W'(4),
      MEMWR    = STATE_W'(5),
      EXECUTER = STATE_W'(6),
      EXECUTEI = STATE_W'(7),
      ALUWB    = STATE_W'(8),
      BRANCH   = STATE_W'(9),
      UNKNOWN  = STATE_W'(10)
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   state_t state_q;
   state_t state_d;

   // Funct[4:1] is consumed by the ALU decoder, not by this block.
   logic unused_funct;
   assign unused_funct = ^Funct[4:1];

   // NOTE: state register uses non-blocking assignment so every flop samples the pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               OP_BR:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWR:    state_d = FETCH;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         // Illegal codes are folded into UNKNOWN's behaviour.
         default:  state_d = (UNKNOWN_HOLD != 0) ? UNKNOWN : FETCH;
      endcase
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      case (state_q)
         FETCH: begin
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR:   ALUSrcB = 2'b01;
         MEMRD:    AdrSrc  = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         EXECUTER: ALUOp = 1'b1;
         EXECUTEI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
         end
         ALUWB:    RegW = 1'b1;
         BRANCH: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
         end
         default: ;
      endcase
   end

   assign State = state_q;

`ifdef MAIN_FSM_RETIRE_CNT_EN
   // Every completion state leaves for FETCH unconditionally, so being in one means this edge retires.
   logic retire;
   assign retire = (state_q == MEMWB) || (state_q == MEMWR) ||
                   (state_q == ALUWB) || (state_q == BRANCH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       RetireCnt <= 32'd0;
      else if (retire) RetireCnt <= RetireCnt + 32'd1;
   end
`endif

endmodule
